uart_frame_parser: RTL
======================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter TIMEOUT_CYC, default 8680, maximum clk cycles allowed between bytes of one frame (20 bit times at 115200 baud, 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz, rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 rx_data  input  8  byte from the upstream UART receiver; valid only while rx_done is high.
REQ-005 rx_done  input  1  one-cycle strobe; one received byte per strobe.
REQ-006 data_out  output  32  last complete frame payload, held until the next frame completes.
REQ-007 data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-008 busy  output  1  high while the parser is in any state other than IDLE.
REQ-009 frame_err  output  1  one-cycle pulse when a partial frame is aborted.

Function
REQ-010 The frame format SHALL be header 0xFF 0xFF followed by 4 payload bytes, sent MSB byte first (FF FF 25 23 51 2F gives 0x2523512F).
REQ-011 The FSM SHALL have the states IDLE, HDR (one 0xFF seen), and DATA (2-bit byte counter 0..3).
REQ-012 IDLE: rx_done with 0xFF SHALL move to HDR; any other byte SHALL stay in IDLE.
REQ-013 HDR: rx_done with 0xFF SHALL move to DATA with count 0; any other byte SHALL return to IDLE, with no frame_err.
REQ-014 DATA: every rx_done byte, including 0xFF, SHALL be payload; the shift register SHALL update as {sr[23:0], rx_data}, and the count SHALL increment.
REQ-015 On the 4th payload byte, data_out SHALL load {sr[23:0], rx_data}, data_valid SHALL pulse high for exactly the next cycle (latency 1 clk from the rx_done edge), and the FSM SHALL return to IDLE.
REQ-016 Bytes arriving after frame completion SHALL be parsed from IDLE; back-to-back frames with zero idle gap SHALL both be accepted.
REQ-017 Cycles in which rx_done is low SHALL not change state, the counter, or the shift register (except for the timeout of REQ-024).
REQ-018 data_out SHALL change only on frame completion; a partial or aborted frame SHALL never alter it.
REQ-019 busy SHALL be registered and reflect the current state (high in HDR and DATA).

Reset
REQ-020 While rst_n is low, state SHALL be IDLE, the counter and shift register 0, data_out 0x00000000, and data_valid, busy and frame_err 0.
REQ-021 A reset asserted mid-frame SHALL discard the partial frame immediately, with no data_valid and no frame_err.
REQ-022 After reset release, the first rx_done SHALL be parsed from IDLE.

Configuration
REQ-023 The macro FRAME_TIMEOUT_EN SHALL compile the inter-byte timeout in or out.
REQ-024 With FRAME_TIMEOUT_EN defined:
- a cycle counter SHALL clear on each rx_done and in IDLE, and increment otherwise;
- when it reaches TIMEOUT_CYC-1 in HDR or DATA, the FSM SHALL return to IDLE, clear the byte count, and pulse frame_err for one cycle;
- if rx_done coincides with the timeout cycle, the byte SHALL win: it is processed normally and no timeout occurs.
REQ-025 Without FRAME_TIMEOUT_EN, no counter SHALL exist, frame_err SHALL be tied 0, and a partial frame SHALL wait indefinitely.

Verification
REQ-026 Bytes FF FF 25 23 51 2F at 434-clk bit spacing -> one data_valid pulse, data_out=0x2523512F, busy low afterwards.
REQ-027 Bytes FF 12 FF FF 01 02 03 04 -> 0x12 resets the header, exactly one data_valid, data_out=0x01020304.
REQ-028 Bytes FF FF FF FF FF FF -> data_out=0xFFFFFFFF; a following FF FF AA BB CC DD with zero gap -> second pulse, 0xAABBCCDD.
REQ-029 FRAME_TIMEOUT_EN defined: FF FF 25 23, then a gap longer than 8680 clk, then FF FF 11 22 33 44 -> one frame_err pulse, data_out unchanged from 0, then 0x11223344.
REQ-030 rst_n pulsed low after FF FF 25 -> all outputs 0 and no data_valid; next FF FF 25 23 51 2F -> 0x2523512F.
REQ-031 rx_done coincident with the timeout cycle -> byte accepted, no frame_err.

Source files
------------

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - FF FF header + 4-byte payload frame parser behind a UART receiver
// Optional inter-byte timeout compiled in with `define FRAME_TIMEOUT_EN
module uart_frame_parser #(
  parameter int TIMEOUT_CYC = 8680
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [23:0] sr;
  logic        timeout;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] tcnt;

  // A byte arriving on the timeout cycle takes priority over the abort
  assign timeout = !rx_done && (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
      if (rx_done || state == IDLE)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout   = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      sr         <= 24'd0;
      data_out   <= 32'd0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (rx_done) begin
        case (state)
          IDLE: begin
            if (rx_data == 8'hFF) begin
              state <= HDR;
              busy  <= 1'b1;
            end
          end
          HDR: begin
            if (rx_data == 8'hFF) begin
              state <= DATA;
              cnt   <= 2'd0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          DATA: begin
            sr  <= {sr[15:0], rx_data};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              data_out   <= {sr, rx_data};
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 2'd0;
            busy  <= 1'b0;
          end
        endcase
      end else if (timeout) begin
        state <= IDLE;
        cnt   <= 2'd0;
        busy  <= 1'b0;
      end
    end
  end

endmodule
